// File: rtl/sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_pkg
// Shared definitions for the single-clock FIFO:
//   - SYNC_FIFO_DEF_WIDTH / SYNC_FIFO_DEF_DEPTH : default word width and
//     address width (capacity = 2**DEPTH)
//   - fifo_status_t : packed bundle of the FIFO status flags, so a parent
//     can route all of them as one signal
//   - thresh_ok()   : legality check of the almost-full/almost-empty
//     thresholds, evaluated at elaboration time
// ---------------------------------------------------------------------------
package sync_fifo_pkg;

   localparam int SYNC_FIFO_DEF_WIDTH = 8;
   localparam int SYNC_FIFO_DEF_DEPTH = 4;

   typedef struct packed {
      logic full;
      logic empty;
      logic afull;
      logic aempty;
      logic ovf;
      logic udf;
   } fifo_status_t;

   // Legal: af in 1..2**depth, ae in 0..2**depth-1.
   function automatic bit thresh_ok(input int depth, input int af, input int ae);
      int cap;
      cap = 1 << depth;
      return (depth >= 1) && (af >= 1) && (af <= cap) && (ae >= 0) && (ae <= cap - 1);
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// ---------------------------------------------------------------------------
// sync_fifo_mem
// 2**DEPTH x WIDTH register array for sync_fifo.
//   clk    : rising-edge clock
//   n_rst  : asynchronous active-low reset (clears only the registered
//            read data, never the array)
//   we     : write enable; wdata stored at waddr on the rising edge
//   waddr  : write index
//   wdata  : write data
//   re     : read enable (registered read port only)
//   raddr  : read index
//   rdata  : read data
// Build option SYNC_FIFO_FWFT_EN:
//   defined   -> rdata is a combinational read of the array at raddr
//   undefined -> rdata is registered, loaded from raddr when re is high
// ---------------------------------------------------------------------------
module sync_fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             we,
   input  logic [DEPTH-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [DEPTH-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   localparam int ENTRIES = 1 << DEPTH;

   logic [WIDTH-1:0] mem_q [0:ENTRIES-1];

   // Storage is deliberately left without reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign rdata = mem_q[raddr];

   // The read enable and reset have no effect on a combinational port.
   logic unused_rd_ctrl;
   assign unused_rd_ctrl = re ^ n_rst;
`else
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem_q[raddr];
      end
   end
`endif

endmodule

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO of 2**DEPTH words of WIDTH bits, with full/empty,
// programmable almost-full/almost-empty, occupancy count and sticky
// overflow/underflow flags.
//
// Ports:
//   clk               : rising-edge clock
//   n_rst             : asynchronous active-low reset
//   valid_write       : write request; data_in stored when accepted
//   data_in           : write data
//   rd_en             : read request (pop)
//   data_out          : read data
//   data_valid        : data_out holds a valid popped / head word
//   f_flag            : full  (count == 2**DEPTH)
//   e_flag            : empty (count == 0)
//   almost_full_flag  : count >= AF_THRESH
//   almost_empty_flag : count <= AE_THRESH
//   count             : occupancy, 0..2**DEPTH
//   overflow          : sticky, a write was attempted while full
//   underflow         : sticky, a read was attempted while empty
//
// Handshake: a write is accepted on an edge where valid_write is high and
// f_flag is low; a read is accepted on an edge where rd_en is high and
// e_flag is low. f_flag/e_flag act as the registered not-ready signals, so
// a write offered while full is dropped (even if a read is accepted on the
// same edge) and a read offered while empty is dropped (even if a write is
// accepted on the same edge). Dropped requests set overflow/underflow.
//
// Build option SYNC_FIFO_FWFT_EN:
//   undefined -> registered read: data_out/data_valid update one edge after
//                the accepted read, data_valid high for one cycle per read
//   defined   -> first-word-fall-through: data_out shows the head word,
//                data_valid = ~e_flag, rd_en acknowledges the shown word
// ---------------------------------------------------------------------------
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH     = SYNC_FIFO_DEF_WIDTH,
   parameter int DEPTH     = SYNC_FIFO_DEF_DEPTH,
   parameter int AF_THRESH = 14,
   parameter int AE_THRESH = 2
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             valid_write,
   input  logic [WIDTH-1:0] data_in,
   input  logic             rd_en,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             f_flag,
   output logic             e_flag,
   output logic             almost_full_flag,
   output logic             almost_empty_flag,
   output logic [DEPTH:0]   count,
   output logic             overflow,
   output logic             underflow
);

   localparam int             CAP     = 1 << DEPTH;
   localparam logic [DEPTH:0] CAP_CNT = (DEPTH + 1)'(CAP);

   localparam fifo_status_t STATUS_RST = '{
      full:   1'b0,
      empty:  1'b1,
      afull:  (AF_THRESH == 0),
      aempty: 1'b1,
      ovf:    1'b0,
      udf:    1'b0
   };

   generate
      if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
         $error("sync_fifo: AF_THRESH/AE_THRESH out of range for DEPTH");
      end
   endgenerate

   // Pointers carry one extra MSB so full and empty differ after wrap.
   logic [DEPTH:0] wr_ptr;
   logic [DEPTH:0] rd_ptr;
   logic [DEPTH:0] count_q;
   logic [DEPTH:0] count_next;
   fifo_status_t   status_q;
   fifo_status_t   status_next;

   logic wr_acc;
   logic rd_acc;
   logic wr_rej;
   logic rd_rej;

   assign wr_acc = valid_write & ~status_q.full;
   assign rd_acc = rd_en       & ~status_q.empty;
   assign wr_rej = valid_write &  status_q.full;
   assign rd_rej = rd_en       &  status_q.empty;

   // All flags derive from the next count so they move on the same edge
   // as count itself.
   always_comb begin
      count_next         = count_q + {{DEPTH{1'b0}}, wr_acc} - {{DEPTH{1'b0}}, rd_acc};
      status_next        = status_q;
      status_next.full   = (count_next == CAP_CNT);
      status_next.empty  = (count_next == '0);
      status_next.afull  = (int'(count_next) >= AF_THRESH);
      status_next.aempty = (int'(count_next) <= AE_THRESH);
      status_next.ovf    = status_q.ovf | wr_rej;
      status_next.udf    = status_q.udf | rd_rej;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_q  <= '0;
         status_q <= STATUS_RST;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count_q  <= count_next;
         status_q <= status_next;
      end
   end

   sync_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .n_rst (n_rst),
      .we    (wr_acc),
      .waddr (wr_ptr[DEPTH-1:0]),
      .wdata (data_in),
      .re    (rd_acc),
      .raddr (rd_ptr[DEPTH-1:0]),
      .rdata (data_out)
   );

`ifdef SYNC_FIFO_FWFT_EN
   assign data_valid = ~status_q.empty;
`else
   logic dv_q;

   // One-cycle strobe marking the word loaded by an accepted read.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         dv_q <= 1'b0;
      end else begin
         dv_q <= rd_acc;
      end
   end

   assign data_valid = dv_q;
`endif

   assign count             = count_q;
   assign f_flag            = status_q.full;
   assign e_flag            = status_q.empty;
   assign almost_full_flag  = status_q.afull;
   assign almost_empty_flag = status_q.aempty;
   assign overflow          = status_q.ovf;
   assign underflow         = status_q.udf;

endmodule

// File: tb/tb_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo
// Directed bench for sync_fifo with default parameters (WIDTH 8, DEPTH 4,
// AF_THRESH 14, AE_THRESH 2). Inputs change 1 time unit after a rising
// edge; outputs are sampled at the same point. Read-data expectations
// follow the build option SYNC_FIFO_FWFT_EN.
// ---------------------------------------------------------------------------
module tb_sync_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             n_rst = 1'b1;
   logic             valid_write = 1'b0;
   logic [WIDTH-1:0] data_in = '0;
   logic             rd_en = 1'b0;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             f_flag;
   logic             e_flag;
   logic             almost_full_flag;
   logic             almost_empty_flag;
   logic [DEPTH:0]   count;
   logic             overflow;
   logic             underflow;

   int n_checks = 0;
   int n_fail   = 0;

   logic [WIDTH-1:0] exp_q[$];

   sync_fifo #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .AF_THRESH (14),
      .AE_THRESH (2)
   ) dut (
      .clk               (clk),
      .n_rst             (n_rst),
      .valid_write       (valid_write),
      .data_in           (data_in),
      .rd_en             (rd_en),
      .data_out          (data_out),
      .data_valid        (data_valid),
      .f_flag            (f_flag),
      .e_flag            (e_flag),
      .almost_full_flag  (almost_full_flag),
      .almost_empty_flag (almost_empty_flag),
      .count             (count),
      .overflow          (overflow),
      .underflow         (underflow)
   );

   // clock
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      valid_write = 1'b0;
      rd_en       = 1'b0;
      data_in     = '0;
      n_rst       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b1;
   endtask

   task automatic write_word(input logic [WIDTH-1:0] d);
      valid_write = 1'b1;
      data_in     = d;
      tick();
      valid_write = 1'b0;
   endtask

   // Pops one word and checks it against exp.
   task automatic read_check(input string tag, input logic [WIDTH-1:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
      n_checks++;
      if (data_out !== exp) begin
         n_fail++;
         $display("FAIL %s data: got %0h expected %0h", tag, data_out, exp);
      end
      n_checks++;
      if (data_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s valid: got %0b expected 1", tag, data_valid);
      end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
`else
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      n_checks++;
      if (data_out !== exp) begin
         n_fail++;
         $display("FAIL %s data: got %0h expected %0h", tag, data_out, exp);
      end
      n_checks++;
      if (data_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s valid: got %0b expected 1", tag, data_valid);
      end
`endif
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      apply_reset();
      n_checks++;
      if (count !== 5'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count); end
      n_checks++;
      if ({e_flag, f_flag, almost_empty_flag, almost_full_flag} !== 4'b1010) begin
         n_fail++;
         $display("FAIL rst_flags: got %4b expected 1010", {e_flag, f_flag, almost_empty_flag, almost_full_flag});
      end
      n_checks++;
      if ({overflow, underflow, data_valid} !== 3'b000) begin
         n_fail++;
         $display("FAIL rst_err_valid: got %3b expected 000", {overflow, underflow, data_valid});
      end
`ifndef SYNC_FIFO_FWFT_EN
      n_checks++;
      if (data_out !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %0h expected 0", data_out); end
`endif
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 16; i++) begin
         write_word(8'(i));
         n_checks++;
         if (count !== 5'(i)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i); end
         n_checks++;
         if (f_flag !== (i == 16)) begin n_fail++; $display("FAIL fill_full[%0d]: got %0b expected %0b", i, f_flag, (i == 16)); end
         n_checks++;
         if (almost_full_flag !== (i >= 14)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %0b expected %0b", i, almost_full_flag, (i >= 14)); end
         n_checks++;
         if (almost_empty_flag !== (i <= 2)) begin n_fail++; $display("FAIL fill_aempty[%0d]: got %0b expected %0b", i, almost_empty_flag, (i <= 2)); end
         n_checks++;
         if (e_flag !== 1'b0) begin n_fail++; $display("FAIL fill_empty[%0d]: got %0b expected 0", i, e_flag); end
      end
   endtask

   task automatic test_overflow();
      write_word(8'hAA);
      n_checks++;
      if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_count: got %0d expected 16", count); end
      n_checks++;
      if ({overflow, f_flag} !== 2'b11) begin n_fail++; $display("FAIL ovf_flags: got %2b expected 11", {overflow, f_flag}); end
      for (int i = 1; i <= 16; i++) begin
         read_check("ovf_drain", 8'(i));
         n_checks++;
         if (count !== 5'(16 - i)) begin n_fail++; $display("FAIL ovf_drain_count[%0d]: got %0d expected %0d", i, count, 16 - i); end
      end
      n_checks++;
      if ({overflow, e_flag} !== 2'b11) begin n_fail++; $display("FAIL ovf_sticky_empty: got %2b expected 11", {overflow, e_flag}); end
      tick();
      n_checks++;
      if (data_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_valid_idle: got %0b expected 0", data_valid); end
`ifndef SYNC_FIFO_FWFT_EN
      n_checks++;
      if (data_out !== 8'h10) begin n_fail++; $display("FAIL ovf_hold: got %0h expected 10", data_out); end
`endif
   endtask

   task automatic test_underflow();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      n_checks++;
      if ({underflow, data_valid, e_flag} !== 3'b101) begin
         n_fail++;
         $display("FAIL udf_flags: got %3b expected 101", {underflow, data_valid, e_flag});
      end
      n_checks++;
      if (count !== 5'd0) begin n_fail++; $display("FAIL udf_count: got %0d expected 0", count); end
`ifndef SYNC_FIFO_FWFT_EN
      n_checks++;
      if (data_out !== 8'h10) begin n_fail++; $display("FAIL udf_hold: got %0h expected 10", data_out); end
`endif
      write_word(8'h55);
      read_check("udf_then_write", 8'h55);
      n_checks++;
      if (underflow !== 1'b1) begin n_fail++; $display("FAIL udf_sticky: got %0b expected 1", underflow); end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] exp;
      apply_reset();
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
         write_word(8'h80 + 8'(i));
         exp_q.push_back(8'h80 + 8'(i));
      end
      for (int k = 0; k < 20; k++) begin
         exp = exp_q.pop_front();
         exp_q.push_back(8'h88 + 8'(k));
`ifdef SYNC_FIFO_FWFT_EN
         n_checks++;
         if (data_out !== exp) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", k, data_out, exp); end
`endif
         valid_write = 1'b1;
         rd_en       = 1'b1;
         data_in     = 8'h88 + 8'(k);
         tick();
`ifndef SYNC_FIFO_FWFT_EN
         n_checks++;
         if (data_out !== exp) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", k, data_out, exp); end
`endif
         n_checks++;
         if (count !== 5'd8) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d expected 8", k, count); end
         n_checks++;
         if (data_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %0b expected 1", k, data_valid); end
      end
      valid_write = 1'b0;
      rd_en       = 1'b0;
      while (exp_q.size() > 0) begin
         read_check("b2b_drain", exp_q.pop_front());
      end
      n_checks++;
      if ({e_flag, count} !== {1'b1, 5'd0}) begin n_fail++; $display("FAIL b2b_end: got %0b/%0d expected 1/0", e_flag, count); end
   endtask

   task automatic test_simultaneous_edges();
      apply_reset();
      for (int i = 0; i < 16; i++) write_word(8'(i));
`ifdef SYNC_FIFO_FWFT_EN
      n_checks++;
      if (data_out !== 8'h00) begin n_fail++; $display("FAIL full_rw_data: got %0h expected 0", data_out); end
`endif
      valid_write = 1'b1;
      rd_en       = 1'b1;
      data_in     = 8'hEE;
      tick();
      valid_write = 1'b0;
      rd_en       = 1'b0;
      n_checks++;
      if (count !== 5'd15) begin n_fail++; $display("FAIL full_rw_count: got %0d expected 15", count); end
      n_checks++;
      if ({overflow, f_flag} !== 2'b10) begin n_fail++; $display("FAIL full_rw_flags: got %2b expected 10", {overflow, f_flag}); end
`ifndef SYNC_FIFO_FWFT_EN
      n_checks++;
      if ({data_valid, data_out} !== {1'b1, 8'h00}) begin
         n_fail++;
         $display("FAIL full_rw_data: got %0b/%0h expected 1/0", data_valid, data_out);
      end
`endif
      for (int i = 1; i < 16; i++) read_check("full_rw_drain", 8'(i));
      valid_write = 1'b1;
      rd_en       = 1'b1;
      data_in     = 8'h77;
      tick();
      valid_write = 1'b0;
      rd_en       = 1'b0;
      n_checks++;
      if (count !== 5'd1) begin n_fail++; $display("FAIL empty_rw_count: got %0d expected 1", count); end
      n_checks++;
      if ({underflow, e_flag} !== 2'b10) begin n_fail++; $display("FAIL empty_rw_flags: got %2b expected 10", {underflow, e_flag}); end
`ifndef SYNC_FIFO_FWFT_EN
      n_checks++;
      if (data_valid !== 1'b0) begin n_fail++; $display("FAIL empty_rw_valid: got %0b expected 0", data_valid); end
`endif
      read_check("empty_rw_read", 8'h77);
   endtask

   task automatic test_async_reset();
      apply_reset();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      for (int i = 0; i < 6; i++) write_word(8'h11 + 8'(i));
      read_check("arst_pre", 8'h11);
      n_checks++;
      if ({count, underflow} !== {5'd5, 1'b1}) begin
         n_fail++;
         $display("FAIL arst_pre_state: got %0d/%0b expected 5/1", count, underflow);
      end
      valid_write = 1'b1;
      data_in     = 8'h99;
      #3;
      n_rst = 1'b0;
      #1;
      n_checks++;
      if (count !== 5'd0) begin n_fail++; $display("FAIL arst_count: got %0d expected 0", count); end
      n_checks++;
      if ({e_flag, f_flag, almost_empty_flag, almost_full_flag} !== 4'b1010) begin
         n_fail++;
         $display("FAIL arst_flags: got %4b expected 1010", {e_flag, f_flag, almost_empty_flag, almost_full_flag});
      end
      n_checks++;
      if ({overflow, underflow, data_valid} !== 3'b000) begin
         n_fail++;
         $display("FAIL arst_err_valid: got %3b expected 000", {overflow, underflow, data_valid});
      end
`ifndef SYNC_FIFO_FWFT_EN
      n_checks++;
      if (data_out !== 8'h00) begin n_fail++; $display("FAIL arst_data: got %0h expected 0", data_out); end
`endif
      valid_write = 1'b0;
      tick();
      n_rst = 1'b1;
      tick();
      n_checks++;
      if ({count, e_flag} !== {5'd0, 1'b1}) begin n_fail++; $display("FAIL arst_after: got %0d/%0b expected 0/1", count, e_flag); end
   endtask

`ifdef SYNC_FIFO_FWFT_EN
   task automatic test_fwft();
      apply_reset();
      write_word(8'h3C);
      n_checks++;
      if ({data_valid, data_out} !== {1'b1, 8'h3C}) begin
         n_fail++;
         $display("FAIL fwft_show: got %0b/%0h expected 1/3c", data_valid, data_out);
      end
      read_check("fwft_ack", 8'h3C);
      n_checks++;
      if (data_valid !== 1'b0) begin n_fail++; $display("FAIL fwft_empty_valid: got %0b expected 0", data_valid); end
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_underflow();
      test_back_to_back();
      test_simultaneous_edges();
      test_async_reset();
`ifdef SYNC_FIFO_FWFT_EN
      test_fwft();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
